// File: rtl/bayer_window_driver.sv
// Frame scanner for the Bayer-to-grey converter: gathers each pixel's 3x3
// neighbourhood (edge-replicated), hands it to the converter, writes the grey result.
module bayer_window_driver #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [199:0]      matriz_a,
    output logic [1:0]        pixel_region,
    output logic              start,
    input  logic [7:0]        conv_result,
    input  logic              conv_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CONV,
        S_WRITE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t              state_q;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [3:0]          k_q;
    logic [3:0]          cap_k;
    logic [7:0]          cap_base_d;
    logic                last_pix;
    logic [ADDR_W-1:0]   fetch_addr_d;
    logic [ADDR_W-1:0]   next_pix_addr_d;
    logic [ADDR_W-1:0]   cen_addr_d;

    logic                busy_q, frame_done_q, rd_en_q, start_q, wr_en_q;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [7:0]          wr_data_q;
    logic [199:0]        matriz_a_q;
    logic [1:0]          pixel_region_q;

    // Read k of the window around (r,c): row r-1+k/3, col c-1+k%3, clamped to the frame.
    function automatic logic [ADDR_W-1:0] src_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c,
                                                    input logic [3:0]       k);
        int sr;
        int sc;
        sr = int'(r) - 1 + int'(k) / 3;
        sc = int'(c) - 1 + int'(k) % 3;
        if (sr < 0) sr = 0;
        else if (sr > IMG_H - 1) sr = IMG_H - 1;
        if (sc < 0) sc = 0;
        else if (sc > IMG_W - 1) sc = IMG_W - 1;
        return ADDR_W'(sr * IMG_W + sc);
    endfunction

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(int'(r) * IMG_W + int'(c));
    endfunction

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end
    end

    // The byte arriving now belongs to the read issued one cycle earlier.
    always_comb begin
        cap_k      = k_q - 4'd1;
        cap_base_d = 8'(40 * (int'(cap_k) / 3) + 8 * (int'(cap_k) % 3));
    end

    assign last_pix        = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
    assign fetch_addr_d    = src_addr(row_q, col_q, k_q + 4'd1);
    assign next_pix_addr_d = src_addr(row_d, col_d, 4'd0);
    assign cen_addr_d      = lin_addr(row_q, col_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            row_q          <= '0;
            col_q          <= '0;
            k_q            <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            rd_en_q        <= 1'b0;
            start_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            matriz_a_q     <= '0;
            pixel_region_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (go) begin
                        row_q     <= '0;
                        col_q     <= '0;
                        k_q       <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= src_addr('0, '0, 4'd0);
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (k_q != 4'd0) begin
                        matriz_a_q[cap_base_d +: 8] <= rd_data;
                    end
                    if (k_q == 4'd9) begin
                        pixel_region_q <= {row_q[0], col_q[0]};
                        start_q        <= 1'b1;
                        state_q        <= S_CONV;
                    end else begin
                        k_q <= k_q + 4'd1;
                        if (k_q == 4'd8) begin
                            rd_en_q <= 1'b0;
                        end else begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= fetch_addr_d;
                        end
                    end
                end
                S_CONV: begin
                    // Window stays frozen until the converter reports, however long it takes.
                    if (conv_done) begin
                        wr_data_q <= conv_result;
                        start_q   <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cen_addr_d;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (last_pix) begin
                        row_q        <= '0;
                        col_q        <= '0;
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_FINISH;
                    end else begin
                        row_q     <= row_d;
                        col_q     <= col_d;
                        k_q       <= '0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= next_pix_addr_d;
                        state_q   <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    frame_done_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign matriz_a     = matriz_a_q;
    assign pixel_region = pixel_region_q;
    assign start        = start_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_bayer_window_driver.sv
// Scoreboard bench for bayer_window_driver on a 4x4 frame with a behavioural
// converter (centre-sample or fixed 0xA5 result, programmable latency).
module tb_bayer_window_driver;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 4;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic          busy, frame_done, rd_en, start, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [7:0]    rd_data;
    logic [199:0]  matriz_a;
    logic [1:0]    pixel_region;
    logic [7:0]    conv_result = 8'h00;
    logic          conv_done   = 1'b0;
    logic [7:0]    wr_data;

    always #5 clk = ~clk;

    bayer_window_driver #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .frame_done(frame_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .matriz_a(matriz_a), .pixel_region(pixel_region), .start(start),
        .conv_result(conv_result), .conv_done(conv_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    logic [7:0] mem [NPIX];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int lat = 1;
    bit fixed_res = 1'b0;
    int ccnt = 0;
    always @(posedge clk) begin
        if (!start) begin
            ccnt      <= 0;
            conv_done <= 1'b0;
        end else if (!conv_done) begin
            ccnt <= ccnt + 1;
            if (ccnt + 1 >= lat) begin
                conv_done   <= 1'b1;
                conv_result <= fixed_res ? 8'hA5 : matriz_a[48 +: 8];
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int exp_rd(input int p, input int k);
        int r = p / W;
        int c = p % W;
        return clampi(r - 1 + k / 3, H - 1) * W + clampi(c - 1 + k % 3, W - 1);
    endfunction

    function automatic logic [199:0] exp_win(input int p);
        logic [199:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[40 * (k / 3) + 8 * (k % 3) +: 8] = mem[exp_rd(p, k)];
        return w;
    endfunction

    int rd_exp[$];
    int wr_exp[$];
    int pix = 0;
    int run = 0;
    bit chg = 1'b0;
    bit start_prev = 1'b0;
    logic [199:0] snap = '0;

    always @(negedge clk) begin
        if (reset) begin
            rd_exp.delete();
            wr_exp.delete();
            pix = 0;
            run = 0;
            chg = 1'b0;
            start_prev = 1'b0;
        end else begin
            if (rd_en) begin
                if (rd_exp.size() == 0) chk("rd_queue", 200'(rd_exp.size()), 200'(1));
                else chk("rd_addr", 200'(rd_addr), 200'(rd_exp.pop_front()));
            end
            if (start && !start_prev) begin
                chk("window", matriz_a, exp_win(pix));
                chk("region", 200'(pixel_region), 200'(((pix / W) % 2) * 2 + (pix % W) % 2));
                snap = matriz_a;
                run = 0;
                chg = 1'b0;
            end
            if (start) begin
                run++;
                if (matriz_a !== snap) chg = 1'b1;
            end
            if (wr_en) begin
                chk("start_in_write", 200'(start), 200'(0));
                chk("conv_len", 200'(run), 200'(lat + 1));
                chk("win_stable", 200'(chg), 200'(0));
                if (wr_exp.size() == 0) chk("wr_queue", 200'(wr_exp.size()), 200'(1));
                else begin
                    int e;
                    e = wr_exp.pop_front();
                    chk("wr_addr", 200'(wr_addr), 200'(e >> 8));
                    chk("wr_data", 200'(wr_data), 200'(e & 255));
                end
                pix++;
            end
            if (frame_done) pix = 0;
            start_prev = start;
        end
    end

    task automatic start_frame();
        for (int p = 0; p < NPIX; p++) begin
            for (int k = 0; k < 9; k++) rd_exp.push_back(exp_rd(p, k));
            wr_exp.push_back(p * 256 + (fixed_res ? 32'hA5 : int'(mem[p])));
        end
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        chk("busy_after_go", 200'(busy), 200'(1));
    endtask

    task automatic wait_frame(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", 200'(seen), 200'(1));
        if (seen) begin
            chk("busy_at_done", 200'(busy), 200'(0));
            @(negedge clk);
            chk("frame_done_pulse", 200'(frame_done), 200'(0));
            chk("busy_idle", 200'(busy), 200'(0));
        end
        chk("wr_q_drained", 200'(wr_exp.size()), 200'(0));
        chk("rd_q_drained", 200'(rd_exp.size()), 200'(0));
    endtask

    initial begin
        bit found;
        bit wr_seen;
        reset = 1'b1;
        go    = 1'b0;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 200'(busy), 200'(0));
        chk("rst_frame_done", 200'(frame_done), 200'(0));
        chk("rst_rd_en", 200'(rd_en), 200'(0));
        chk("rst_start", 200'(start), 200'(0));
        chk("rst_wr_en", 200'(wr_en), 200'(0));
        chk("rst_rd_addr", 200'(rd_addr), 200'(0));
        chk("rst_wr_addr", 200'(wr_addr), 200'(0));
        chk("rst_wr_data", 200'(wr_data), 200'(0));
        chk("rst_matriz_a", matriz_a, 200'(0));
        chk("rst_region", 200'(pixel_region), 200'(0));
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // uniform frame, fast converter
        start_frame();
        wait_frame(2000);

        // ramp frame; go pulses while busy must be ignored
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        start_frame();
        repeat (40) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        repeat (60) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        wait_frame(2000);

        // slow converter with constant result
        lat = 20;
        fixed_res = 1'b1;
        start_frame();
        wait_frame(3000);

        // reset during CONV of pixel 5, then a fresh frame
        fixed_res = 1'b0;
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (start && pix == 5) found = 1'b1;
        end
        chk("reached_pix5", 200'(found), 200'(1));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_start", 200'(start), 200'(0));
        chk("rstmid_busy", 200'(busy), 200'(0));
        chk("rstmid_wr_en", 200'(wr_en), 200'(0));
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        wr_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr_en || start || rd_en) wr_seen = 1'b1;
        end
        chk("idle_after_rst", 200'(wr_seen), 200'(0));
        start_frame();
        wait_frame(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bayer_window_driver.md
Name: bayer_window_driver

Overview:
- Frame-level controller that feeds the Bayer-to-grey ALU stage.
- Scans a raw Bayer frame (GRBG, 8-bit samples) stored in source memory, pixel by pixel in row-major order.
- For each pixel it assembles the 3x3 neighbourhood into the 200-bit 5x5 window bus, derives the pixel region, runs the start/done handshake with the converter, and writes the 8-bit grey result to destination memory.

Parameters:
IMG_W, 160, frame width in pixels (>=2)
IMG_H, 120, frame height in pixels (>=2)
ADDR_W, 15, address width of source and destination memories (IMG_W*IMG_H <= 2**ADDR_W)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
go  input  1  pulse: start processing one frame (sampled only in IDLE)
busy  output  1  high from the cycle after go is accepted until frame_done
frame_done  output  1  one-cycle pulse after the last pixel is written
rd_en  output  1  source memory read strobe
rd_addr  output  ADDR_W  source address = row*IMG_W+col
rd_data  input  8  source data, valid exactly 1 cycle after rd_en
matriz_a  output  200  window bus; byte (y,x) at bits [40*y+8*x +: 8]
pixel_region  output  2  {row[0], col[0]} of centre pixel
start  output  1  converter run level; held high until conv_done
conv_result  input  8  grey value from converter
conv_done  input  1  converter completion level (high while result valid)
wr_en  output  1  destination write strobe, one cycle per pixel
wr_addr  output  ADDR_W  destination address = row*IMG_W+col of centre
wr_data  output  8  grey value written

Behaviour:
- Reset (any state, including mid-frame): state=IDLE; busy, frame_done, rd_en, start, wr_en=0; rd_addr, wr_addr, wr_data, matriz_a, pixel_region=0; row/col counters=0. Partial frame is abandoned, with no further writes.
- FSM states: IDLE, FETCH, CONV, WRITE, NEXT, FINISH.
- IDLE: on go=1, clear row/col, set busy, go to FETCH. go is ignored in all other states.
- FETCH: 9 reads issued on consecutive cycles, k=0..8, with y=k/3 and x=k%3.
  - Source coordinate = (clamp(row-1+y), clamp(col-1+x)), clamped to [0,IMG_H-1]/[0,IMG_W-1]. Edge pixels are replicated.
  - The byte returned one cycle after read k is stored at window position (y,x). Window bytes with y>2 or x>2 are always 0.
  - FETCH lasts 10 cycles: 9 issues plus the final capture. rd_en is high for exactly 9 cycles.
  - On exit, pixel_region is set to {row[0],col[0]}.
- CONV: start=1. matriz_a and pixel_region are held stable. The state waits indefinitely for conv_done=1, so there is no fixed latency assumption. On conv_done, conv_result is captured into wr_data and the FSM goes to WRITE.
- WRITE: start=0 (this guarantees at least one low cycle so the converter re-arms). wr_en=1 for one cycle with wr_addr=row*IMG_W+col.
- NEXT: col increments. At col=IMG_W-1, col wraps to 0 and row increments. If the last pixel (IMG_H-1, IMG_W-1) was just written, go to FINISH; otherwise go to FETCH.
- FINISH: frame_done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- start never goes high in any state except CONV. A conv_done seen outside CONV is ignored.
- Address arithmetic is unsigned and ADDR_W wide; no overflow occurs given the parameter constraint.
- Per-pixel cycle count = 10 + converter latency + 1 (WRITE) + 1 (NEXT).

Test Plan:
- 4x4 frame, all samples 100, real converter attached: go -> 16 writes, addresses 0..15 in order, every wr_data=100; frame_done pulses once; busy is low after it.
- 4x4 frame with samples = address index: pixel (0,0) read sequence is addrs 0,0,1,0,0,1,4,4,5. The window holds those values at (y,x) positions 0..2 and zeros elsewhere; pixel_region=00.
- pixel_region sequence for row 1 of a 4x4 frame -> 10,11,10,11; row 0 -> 00,01,00,01.
- Converter stub asserting conv_done 20 cycles after start rises, result 0xA5: start stays high and matriz_a is stable for 20 cycles; exactly one wr_en with wr_data=0xA5; start is low in the WRITE cycle.
- go pulsed again while busy: no restart, counters unaffected, total writes still 16.
- reset asserted during CONV of pixel 5: next cycle start=0, busy=0, no wr_en; a fresh go restarts from address 0.
